// File: rtl/digit_seq_pkg.sv
// digit_seq_pkg: shared types and constants for the digit sequencer.
//   deb_state_e : debounce FSM states
//   DIGIT_W     : digit width (3 bits, drives decoder inputs A,B,C)
//   DIGIT_MAX   : largest digit value before wrap-around
package digit_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_e;

    localparam int DIGIT_W = 3;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 3'd7;

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchronizer plus press/release debounce FSM.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   raw : asynchronous raw button, active high
//   evt : one-cycle registered pulse per qualified press (no auto-repeat)
module button_debouncer
    import digit_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q;
    logic          s_q;
    logic          evt_q;
    logic [CW-1:0] cnt_q;
    deb_state_e    state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b0;
            s_q     <= 1'b0;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            sync_q <= raw;
            s_q    <= sync_q;
            evt_q  <= 1'b0;
            case (state_q)
                IDLE: if (s_q) begin
                    cnt_q <= '0;
                    // a single-cycle debounce accepts the press on first sight
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_q <= PRESSED;
                        evt_q   <= 1'b1;
                    end else begin
                        state_q <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: if (!s_q) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == LAST) begin
                        state_q <= PRESSED;
                        evt_q   <= 1'b1;
                    end
                end
                PRESSED: if (!s_q) begin
                    state_q <= RELEASE_WAIT;
                    cnt_q   <= '0;
                end
                RELEASE_WAIT: if (s_q) begin
                    state_q <= PRESSED;
                end else if (cnt_q == LAST) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/digit_sequencer_3b.sv
// digit_sequencer_3b: debounced up/down buttons step a modulo-8 digit for the 7-seg decoder.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   btn_up/btn_down : raw asynchronous buttons, active high
//   run             : auto-run enable (only when SEQ_AUTORUN_EN is defined)
//   A,B,C           : registered digit, A = MSB
//   changed         : one-cycle pulse in the first cycle A,B,C hold a new value
// Define SEQ_AUTORUN_EN to add the run port, TICK_DIV parameter and auto-step prescaler.
module digit_sequencer_3b
    import digit_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
`ifdef SEQ_AUTORUN_EN
    ,
    parameter int TICK_DIV = 50000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
`ifdef SEQ_AUTORUN_EN
    input  logic run,
`endif
    output logic A,
    output logic B,
    output logic C,
    output logic changed
);

    logic               up_evt;
    logic               down_evt;
    logic               tick;
    logic               changed_q;
    logic [DIGIT_W-1:0] d_q;
    logic [DIGIT_W-1:0] d_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk),
        .rst(rst),
        .raw(btn_up),
        .evt(up_evt)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk),
        .rst(rst),
        .raw(btn_down),
        .evt(down_evt)
    );

`ifdef SEQ_AUTORUN_EN
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] pre_q;

    assign tick = run && (pre_q == PW'(TICK_DIV - 1));

    // any button event restarts the prescaler, so a coincident tick is dropped
    always_ff @(posedge clk) begin
        if (rst || !run || up_evt || down_evt || tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end
`else
    assign tick = 1'b0;
`endif

    // button events take priority over the tick; both buttons together hold d
    always_comb begin
        d_d = (up_evt && !down_evt)            ? ((d_q == DIGIT_MAX) ? '0 : d_q + 1'b1) :
              (down_evt && !up_evt)            ? d_q - 1'b1 :
              (!up_evt && !down_evt && tick)   ? ((d_q == DIGIT_MAX) ? '0 : d_q + 1'b1) :
                                                 d_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q       <= '0;
            changed_q <= 1'b0;
        end else begin
            d_q       <= d_d;
            changed_q <= (d_d != d_q);
        end
    end

    assign {A, B, C} = d_q;
    assign changed   = changed_q;

endmodule

// File: tb/tb_digit_sequencer_3b.sv
// tb_digit_sequencer_3b: directed self-checking bench for digit_sequencer_3b (DEBOUNCE_CYCLES=4, TICK_DIV=8).
module tb_digit_sequencer_3b;

    localparam int DC = 4;
`ifdef SEQ_AUTORUN_EN
    localparam int TD = 8;
    logic run = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic       A, B, C, changed;
    logic [2:0] abc;
    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         chg_seen = 0;
    int         c0;

    assign abc = {A, B, C};

    always #5 clk = ~clk;

    digit_sequencer_3b #(
        .DEBOUNCE_CYCLES(DC)
`ifdef SEQ_AUTORUN_EN
        ,
        .TICK_DIV(TD)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_up(btn_up),
        .btn_down(btn_down),
`ifdef SEQ_AUTORUN_EN
        .run(run),
`endif
        .A(A),
        .B(B),
        .C(C),
        .changed(changed)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance n rising edges, sampling 1 time unit after each and tallying changed pulses
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (changed === 1'b1) chg_seen++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic press(input logic u, input logic dn);
        btn_up   = u;
        btn_down = dn;
        step(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        step(16);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_abc", abc, 0);
        chk("rst_changed", changed, 0);

        // held press: digit moves on the 7th edge after first sample, exactly once
        btn_up = 1'b1;
        step(6);
        chk("hold_e6", abc, 0);
        step(1);
        chk("hold_e7", abc, 1);
        chk("hold_e7_changed", changed, 1);
        step(1);
        chk("hold_changed_drop", changed, 0);
        c0 = chg_seen;
        step(12);
        chk("hold_no_repeat", abc, 1);
        chk("hold_no_repeat_chg", 8'(chg_seen - c0), 0);
        btn_up = 1'b0;
        step(16);

        // eight up presses wrap 7 -> 0, then a down press wraps 0 -> 7
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            press(1'b1, 1'b0);
            chk($sformatf("up_%0d", i), abc, 8'(i % 8));
        end
        press(1'b0, 1'b1);
        chk("down_wrap", abc, 7);

        // glitches of 1, 2, 3 cycles are rejected
        do_reset();
        c0 = chg_seen;
        for (int w = 1; w <= 3; w++) begin
            btn_up = 1'b1;
            step(w);
            btn_up = 1'b0;
            step(10);
        end
        chk("glitch_abc", abc, 0);
        chk("glitch_changed", 8'(chg_seen - c0), 0);

        // both buttons qualified together hold d=5
        do_reset();
        repeat (5) press(1'b1, 1'b0);
        chk("pre_both", abc, 5);
        c0 = chg_seen;
        press(1'b1, 1'b1);
        chk("both_abc", abc, 5);
        chk("both_changed", 8'(chg_seen - c0), 0);

        // reset two cycles into a press at d=3, then full re-qualification
        do_reset();
        repeat (3) press(1'b1, 1'b0);
        chk("pre_rst_mid", abc, 3);
        btn_up = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        chk("rst_mid_abc", abc, 0);
        rst = 1'b0;
        step(6);
        chk("requal_e6", abc, 0);
        step(1);
        chk("requal_e7", abc, 1);
        btn_up = 1'b0;
        step(16);

`ifdef SEQ_AUTORUN_EN
        // auto-run ticks every 8 edges
        do_reset();
        run = 1'b1;
        step(7);
        chk("ar_e7", abc, 0);
        step(1);
        chk("ar_e8", abc, 1);
        chk("ar_e8_changed", changed, 1);
        step(32);
        chk("ar_e40", abc, 5);
        // down event lands on the tick at edge 48: net -1, next tick at 56
        step(1);
        btn_down = 1'b1;
        step(7);
        chk("ar_dn_e48", abc, 4);
        step(7);
        chk("ar_e55", abc, 4);
        step(1);
        chk("ar_e56", abc, 5);
        btn_down = 1'b0;
        run = 1'b0;
        step(16);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
